// File: rtl/ddr3_tg_pkg.sv
// Shared encodings for the DDR3 traffic generator: MC commands, FSM states, data patterns
// and the PRBS31 polynomial.
package ddr3_tg_pkg;

  localparam logic [2:0] CmdWrite = 3'b000;
  localparam logic [2:0] CmdRead  = 3'b001;

  // x^31 + x^28 + 1, Fibonacci form: feedback = s[30] ^ s[27], shifted in at bit 0.
  localparam logic [30:0] PrbsSeed  = 31'h1;
  localparam int unsigned PrbsTapHi = 30;
  localparam int unsigned PrbsTapLo = 27;

  typedef enum logic [2:0] {
    StIdle,
    StWrCmd,
    StWrData,
    StRd,
    StRdDrain,
    StFin
  } tg_state_e;

  typedef enum logic [1:0] {
    ModeAddr    = 2'd0,
    ModePrbs    = 2'd1,
    ModeWalk    = 2'd2,
    ModeInvAddr = 2'd3
  } tg_mode_e;

  function automatic logic prbs_bit(input logic [30:0] s);
    return s[PrbsTapHi] ^ s[PrbsTapLo];
  endfunction

endpackage

// File: rtl/ddr3_tg_pattern.sv
// Pattern word generator. One instance produces write data, a second regenerates the
// expected read data; both see the same seed/advance sequence.
module ddr3_tg_pattern
  import ddr3_tg_pkg::*;
#(
  parameter int unsigned APP_DATA_WIDTH = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      seed_load,
  input  logic [30:0]               seed,
  input  logic                      advance,
  input  logic [1:0]                mode,
  input  logic [15:0]               addr_lo,
  output logic [APP_DATA_WIDTH-1:0] word
);

  localparam int unsigned WalkW = (APP_DATA_WIDTH > 1) ? $clog2(APP_DATA_WIDTH) : 1;
  localparam int unsigned Lanes = APP_DATA_WIDTH / 16;
  localparam logic [WalkW-1:0] WalkLast = WalkW'(APP_DATA_WIDTH - 1);

  logic [30:0]               lfsr_q;
  logic [WalkW-1:0]          walk_q;
  logic [30:0]               prbs_s;
  logic [30:0]               lfsr_next;
  logic [APP_DATA_WIDTH-1:0] prbs_word;
  logic [APP_DATA_WIDTH-1:0] addr_word;

  // Word bit i is the i-th LFSR output; the state then jumps a whole word ahead.
  always_comb begin
    prbs_s    = lfsr_q;
    prbs_word = '0;
    for (int i = 0; i < APP_DATA_WIDTH; i++) begin
      prbs_word[i] = prbs_bit(prbs_s);
      prbs_s       = {prbs_s[29:0], prbs_bit(prbs_s)};
    end
    lfsr_next = prbs_s;
  end

  always_comb begin
    addr_word = '0;
    for (int k = 0; k < Lanes; k++) begin
      addr_word[16*k +: 16] = addr_lo + 16'(k);
    end
  end

  always_comb begin
    word = '0;
    unique case (tg_mode_e'(mode))
      ModeAddr:    word = addr_word;
      ModePrbs:    word = prbs_word;
      ModeWalk:    word[walk_q] = 1'b1;
      ModeInvAddr: word = ~addr_word;
      default:     word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= PrbsSeed;
      walk_q <= '0;
    end else if (seed_load) begin
      lfsr_q <= seed;
      walk_q <= '0;
    end else if (advance) begin
      lfsr_q <= lfsr_next;
      walk_q <= (walk_q == WalkLast) ? '0 : walk_q + WalkW'(1);
    end
  end

endmodule

// File: rtl/ddr3_traffic_gen.sv
// DDR3 traffic generator/checker on the Gowin MC user interface: write a window of bursts,
// read it back in order and compare, with looping, throttled reads and a read watchdog.
module ddr3_traffic_gen
  import ddr3_tg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 28,
  parameter int unsigned APP_DATA_WIDTH  = 128,
  parameter int unsigned APP_MASK_WIDTH  = 16,
  parameter int unsigned BASE_ADDR       = 0,
  parameter int unsigned ADDR_STEP       = 8,
  parameter int unsigned NUM_BURSTS      = 1024,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic                      loop_en,
  input  logic                      stop,
  input  logic                      init_calib_complete,
  input  logic                      cmd_ready,
  output logic                      cmd_en,
  output logic [2:0]                cmd,
  output logic [ADDR_WIDTH-1:0]     addr,
  input  logic                      wr_data_rdy,
  output logic                      wr_data_en,
  output logic [APP_DATA_WIDTH-1:0] wr_data,
  output logic                      wr_data_end,
  output logic [APP_MASK_WIDTH-1:0] wr_data_mask,
  input  logic                      rd_data_valid,
  input  logic [APP_DATA_WIDTH-1:0] rd_data,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [15:0]               err_cnt,
  output logic [ADDR_WIDTH-1:0]     first_err_addr,
  output logic [15:0]               pass_cnt
);

  localparam int unsigned IdxW = $clog2(NUM_BURSTS + 1);
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] BaseA   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] StepA   = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [IdxW-1:0]       NumB    = IdxW'(NUM_BURSTS);
  localparam logic [IdxW-1:0]       LastIdx = IdxW'(NUM_BURSTS - 1);
  localparam logic [OutW-1:0]       MaxOut  = OutW'(MAX_OUTSTANDING);
  localparam logic [TmoW-1:0]       TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  tg_state_e                 state_q;
  tg_mode_e                  mode_q;
  logic [IdxW-1:0]           idx_q;
  logic [ADDR_WIDTH-1:0]     chk_addr_q;
  logic [OutW-1:0]           out_q;
  logic [TmoW-1:0]           tmo_q;
  logic                      stop_q;

  logic                      start_go, loop_go, gen_load, wr_adv;
  logic                      in_rd, rd_chk, rd_acc, mismatch, calib_lost, tmo_fire;
  logic [30:0]               gen_seed;
  logic [IdxW-1:0]           idx_rd_nxt;
  logic [OutW-1:0]           out_nxt;
  logic [APP_DATA_WIDTH-1:0] wr_word, exp_word;

  assign wr_data_mask = '0;

  assign start_go   = (state_q == StIdle) && start && init_calib_complete;
  assign loop_go    = (state_q == StFin) && loop_en && !stop_q && !stop && !error;
  assign gen_load   = start_go || loop_go;
  // Pass p (p completed so far) runs with seed PrbsSeed + p.
  assign gen_seed   = start_go ? PrbsSeed : PrbsSeed + 31'(pass_cnt) + 31'd1;
  assign wr_adv     = (state_q == StWrData) && wr_data_rdy;
  assign in_rd      = (state_q == StRd) || (state_q == StRdDrain);
  assign rd_chk     = in_rd && rd_data_valid;
  assign rd_acc     = (state_q == StRd) && cmd_en && cmd_ready;
  assign mismatch   = rd_chk && (rd_data != exp_word);
  assign calib_lost = (state_q != StIdle) && !init_calib_complete;
  assign tmo_fire   = in_rd && (out_q != '0) && !rd_data_valid && (tmo_q == TmoLast);
  assign idx_rd_nxt = idx_q + IdxW'(rd_acc);
  assign out_nxt    = out_q + OutW'(rd_acc) - OutW'(rd_chk);

  ddr3_tg_pattern #(.APP_DATA_WIDTH(APP_DATA_WIDTH)) u_wr_gen (
    .clk       (clk),
    .rst       (rst),
    .seed_load (gen_load),
    .seed      (gen_seed),
    .advance   (wr_adv),
    .mode      (mode_q),
    .addr_lo   (addr[15:0]),
    .word      (wr_word)
  );

  ddr3_tg_pattern #(.APP_DATA_WIDTH(APP_DATA_WIDTH)) u_exp_gen (
    .clk       (clk),
    .rst       (rst),
    .seed_load (gen_load),
    .seed      (gen_seed),
    .advance   (rd_chk),
    .mode      (mode_q),
    .addr_lo   (chk_addr_q[15:0]),
    .word      (exp_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      mode_q         <= ModeAddr;
      idx_q          <= '0;
      chk_addr_q     <= BaseA;
      out_q          <= '0;
      tmo_q          <= '0;
      stop_q         <= 1'b0;
      cmd_en         <= 1'b0;
      cmd            <= CmdWrite;
      addr           <= BaseA;
      wr_data_en     <= 1'b0;
      wr_data_end    <= 1'b0;
      wr_data        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass_cnt       <= '0;
    end else begin
      if (state_q != StIdle && stop) stop_q <= 1'b1;

      // Read data returns in order, so the check address simply walks with each word.
      if (rd_chk) chk_addr_q <= chk_addr_q + StepA;
      if (mismatch) begin
        error <= 1'b1;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (err_cnt == 16'd0) first_err_addr <= chk_addr_q;
      end
      out_q <= out_nxt;

      if (!in_rd || out_q == '0 || rd_data_valid) tmo_q <= '0;
      else                                       tmo_q <= tmo_q + TmoW'(1);

      if (calib_lost || tmo_fire) begin
        error       <= 1'b1;
        done        <= 1'b1;
        busy        <= 1'b0;
        cmd_en      <= 1'b0;
        wr_data_en  <= 1'b0;
        wr_data_end <= 1'b0;
        stop_q      <= 1'b0;
        state_q     <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_go) begin
              busy           <= 1'b1;
              done           <= 1'b0;
              error          <= 1'b0;
              err_cnt        <= '0;
              first_err_addr <= '0;
              pass_cnt       <= '0;
              mode_q         <= tg_mode_e'(mode);
              idx_q          <= '0;
              addr           <= BaseA;
              chk_addr_q     <= BaseA;
              out_q          <= '0;
              stop_q         <= 1'b0;
              cmd            <= CmdWrite;
              cmd_en         <= 1'b1;
              state_q        <= StWrCmd;
            end
          end
          StWrCmd: begin
            if (cmd_ready) begin
              cmd_en      <= 1'b0;
              wr_data_en  <= 1'b1;
              wr_data_end <= 1'b1;
              wr_data     <= wr_word;
              state_q     <= StWrData;
            end
          end
          StWrData: begin
            if (wr_data_rdy) begin
              wr_data_en  <= 1'b0;
              wr_data_end <= 1'b0;
              cmd_en      <= 1'b1;
              if (idx_q == LastIdx) begin
                idx_q   <= '0;
                addr    <= BaseA;
                cmd     <= CmdRead;
                state_q <= StRd;
              end else begin
                idx_q   <= idx_q + IdxW'(1);
                addr    <= addr + StepA;
                state_q <= StWrCmd;
              end
            end
          end
          StRd: begin
            idx_q <= idx_rd_nxt;
            if (rd_acc) addr <= addr + StepA;
            if (idx_rd_nxt == NumB) begin
              cmd_en  <= 1'b0;
              state_q <= StRdDrain;
            end else begin
              cmd_en <= (out_nxt < MaxOut);
            end
          end
          StRdDrain: begin
            if (out_q == '0) state_q <= StFin;
          end
          StFin: begin
            pass_cnt <= pass_cnt + 16'd1;
            if (loop_go) begin
              idx_q      <= '0;
              addr       <= BaseA;
              chk_addr_q <= BaseA;
              cmd        <= CmdWrite;
              cmd_en     <= 1'b1;
              state_q    <= StWrCmd;
            end else begin
              done    <= 1'b1;
              busy    <= 1'b0;
              stop_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
